word_line_responder: RTL and testbench

- Responder for the CPU-side word memory interface: mem_read/mem_write, mem_byte_enable, 16-bit address and data.
- Backed by the 128-bit line-wide physical memory interface (pmem_*).
- Holds a single 8-word line buffer with valid and dirty bits: write-back, write-allocate.
- Sits between the pipeline's data-memory port and the L2/physical memory. It is the reference single-line responder for the lc3b word protocol.

---
 rtl/word_line_responder.sv | 173 +++++++++++++++++
 tb/tb_word_line_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/word_line_responder.sv
// +----------------------------------------------------------------------------+
// | word_line_responder: single-line write-back, write-allocate word responder |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module word_line_responder #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            mem_byte_enable,
  input  logic [15:0]           mem_wdata,
  output logic [15:0]           mem_rdata,
  output logic                  mem_resp,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [127:0]          pmem_wdata,
  input  logic [127:0]          pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int TAG_W = ADDR_WIDTH - 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    FETCH = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  logic              valid;
  logic              dirty;
  logic [TAG_W-1:0]  tag;
  logic [127:0]      line;

  // Request captured on a miss; live inputs are ignored until it completes.
  logic [TAG_W-1:0]  req_tag;
  logic [2:0]        req_idx;
  logic [1:0]        req_be;
  logic [15:0]       req_wdata;
  logic              req_write;

  logic [TAG_W-1:0]  cur_tag;
  logic [6:0]        cur_off;
  logic [6:0]        req_off;
  logic              cur_req;
  logic              cur_write;
  logic              hit;
  logic [15:0]       hit_merged;
  logic [15:0]       fill_word;
  logic [15:0]       fill_merged;
  logic [127:0]      fill_line;
  logic              unused_addr_lsb;

  function automatic logic [15:0] merge_bytes(input logic [15:0] old_word,
                                              input logic [1:0]  be,
                                              input logic [15:0] wdata);
    merge_bytes = {be[1] ? wdata[15:8] : old_word[15:8],
                   be[0] ? wdata[7:0]  : old_word[7:0]};
  endfunction

  assign cur_tag         = mem_address[ADDR_WIDTH-1:4];
  assign cur_off         = {mem_address[3:1], 4'b0000};
  assign req_off         = {req_idx, 4'b0000};
  assign cur_req         = mem_read | mem_write;
  assign cur_write       = mem_write & ~mem_read;
  assign hit             = valid && (tag == cur_tag);
  assign hit_merged      = merge_bytes(line[cur_off +: 16], mem_byte_enable, mem_wdata);
  assign fill_word       = pmem_rdata[req_off +: 16];
  assign fill_merged     = merge_bytes(fill_word, req_be, req_wdata);
  assign pmem_wdata      = line;
  assign unused_addr_lsb = mem_address[0];

  always_comb begin
    fill_line = pmem_rdata;
    if (req_write) begin
      fill_line[req_off +: 16] = fill_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      valid        <= 1'b0;
      dirty        <= 1'b0;
      tag          <= '0;
      line         <= '0;
      req_tag      <= '0;
      req_idx      <= '0;
      req_be       <= '0;
      req_wdata    <= '0;
      req_write    <= 1'b0;
      mem_rdata    <= '0;
      mem_resp     <= 1'b0;
      pmem_address <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
    end else begin
      mem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (cur_req) begin
            if (hit) begin
              if (cur_write) begin
                line[cur_off +: 16] <= hit_merged;
                mem_rdata           <= hit_merged;
                if (mem_byte_enable != 2'b00) begin
                  dirty <= 1'b1;
                end
              end else begin
                mem_rdata <= line[cur_off +: 16];
              end
              mem_resp <= 1'b1;
              state    <= RESP;
            end else begin
              req_tag   <= cur_tag;
              req_idx   <= mem_address[3:1];
              req_be    <= mem_byte_enable;
              req_wdata <= mem_wdata;
              req_write <= cur_write;
              if (valid && dirty) begin
                pmem_write   <= 1'b1;
                pmem_address <= {tag, 4'b0000};
                state        <= WB;
              end else begin
                pmem_read    <= 1'b1;
                pmem_address <= {cur_tag, 4'b0000};
                state        <= FETCH;
              end
            end
          end
        end
        WB: begin
          if (pmem_resp) begin
            dirty        <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_address <= {req_tag, 4'b0000};
            state        <= FETCH;
          end
        end
        FETCH: begin
          // Refill and the pending access complete on the same edge.
          if (pmem_resp) begin
            pmem_read <= 1'b0;
            line      <= fill_line;
            tag       <= req_tag;
            valid     <= 1'b1;
            dirty     <= req_write && (req_be != 2'b00);
            mem_rdata <= req_write ? fill_merged : fill_word;
            mem_resp  <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_word_line_responder.sv
// Directed scoreboard bench for word_line_responder with a behavioural line memory.
`default_nettype none

module tb_word_line_responder;

  logic         clk;
  logic         rst_n;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  word_line_responder #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] data;
  } acc_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           last_resp_cyc = -10;
  bit           hold = 0;
  acc_t         plog[$];
  logic [15:0]  exp_q[$];
  logic [127:0] store[logic [15:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Default line content: word k of line A is {A[15:12],12'h000} + k.
  function automatic logic [127:0] pattern(input logic [15:0] a);
    logic [127:0] l;
    for (int k = 0; k < 8; k++) l[k*16 +: 16] = {a[15:12], 12'h000} + 16'(k);
    return l;
  endfunction

  function automatic logic [127:0] line_of(input logic [15:0] a);
    if (store.exists(a)) return store[a];
    return pattern(a);
  endfunction

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Line memory: answers any request three cycles after it appears.
  initial begin
    int lat;
    lat = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (pmem_read || pmem_write) begin
        chki("pmem_rd_wr_exclusive", int'(pmem_read && pmem_write), 0);
      end
      if (rst_n && !hold && (pmem_read ^ pmem_write)) begin
        lat++;
        if (lat == 3) begin
          lat = 0;
          plog.push_back('{wr: pmem_write, addr: pmem_address, data: pmem_wdata});
          if (pmem_write) store[pmem_address] = pmem_wdata;
          else pmem_rdata = line_of(pmem_address);
          pmem_resp     = 1'b1;
          last_resp_cyc = cyc;
        end
      end else begin
        lat = 0;
      end
    end
  end

  task automatic req(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [1:0] be, input logic [15:0] wd,
                     input logic [15:0] exp, input bit is_hit, input string tag);
    int n0, n;
    bit got;
    n0  = plog.size();
    n   = 0;
    got = 0;
    exp_q.push_back(exp);
    @(negedge clk);
    mem_address = a; mem_read = rd; mem_write = wr;
    mem_byte_enable = be; mem_wdata = wd;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_resp) begin got = 1; n = i + 1; break; end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    chki({tag, "_resp_seen"}, int'(got), 1);
    if (got) begin
      chk16({tag, "_rdata"}, mem_rdata, exp_q.pop_front());
      if (is_hit) begin
        chki({tag, "_hit_latency"}, n, 1);
        chki({tag, "_no_pmem"}, plog.size(), n0);
      end else begin
        chki({tag, "_miss_latency"}, cyc, last_resp_cyc + 1);
      end
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    bit got;
    logic [127:0] wb_exp;
    rst_n = 1'b0;
    mem_address = '0; mem_read = 0; mem_write = 0; mem_byte_enable = '0; mem_wdata = '0;
    repeat (2) @(negedge clk);
    chk16("rst_mem_resp", 16'(mem_resp), 16'h0);
    chk16("rst_mem_rdata", mem_rdata, 16'h0);
    chk16("rst_pmem_ctl", {14'b0, pmem_read, pmem_write}, 16'h0);
    chk16("rst_pmem_address", pmem_address, 16'h0);
    chk128("rst_pmem_wdata", pmem_wdata, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold read miss
    n0 = plog.size();
    req(1, 0, 16'h1234, 2'b00, 16'h0, 16'h1002, 0, "cold_read");
    chki("cold_read_pmem_count", plog.size(), n0 + 1);
    if (plog.size() == n0 + 1) begin
      chki("cold_read_is_read", int'(plog[n0].wr), 0);
      chk16("cold_read_addr", plog[n0].addr, 16'h1230);
    end

    req(1, 0, 16'h123E, 2'b00, 16'h0, 16'h1007, 1, "read_hit");
    req(0, 1, 16'h1232, 2'b10, 16'hABCD, 16'hAB01, 1, "byte_write_hit");
    req(1, 0, 16'h1232, 2'b00, 16'h0, 16'hAB01, 1, "read_after_write");
    // Read and write together behave as a read and leave the line alone.
    req(1, 1, 16'h1234, 2'b11, 16'hFFFF, 16'h1002, 1, "rd_wr_both");
    req(1, 0, 16'h1234, 2'b00, 16'h0, 16'h1002, 1, "rd_wr_both_unmodified");

    // Dirty eviction
    wb_exp = pattern(16'h1230);
    wb_exp[31:16] = 16'hAB01;
    n0 = plog.size();
    req(1, 0, 16'h5670, 2'b00, 16'h0, 16'h5000, 0, "dirty_evict");
    chki("evict_pmem_count", plog.size(), n0 + 2);
    if (plog.size() == n0 + 2) begin
      chki("evict_first_is_write", int'(plog[n0].wr), 1);
      chk16("evict_wb_addr", plog[n0].addr, 16'h1230);
      chk16("evict_wb_word1", plog[n0].data[31:16], 16'hAB01);
      chk128("evict_wb_line", plog[n0].data, wb_exp);
      chki("evict_then_read", int'(plog[n0+1].wr), 0);
      chk16("evict_fetch_addr", plog[n0+1].addr, 16'h5670);
    end

    // Write miss with empty byte mask
    do_reset();
    n0 = plog.size();
    req(0, 1, 16'h9000, 2'b00, 16'hFFFF, 16'h9000, 0, "write_be00_miss");
    chki("be00_fetch_count", plog.size(), n0 + 1);
    if (plog.size() == n0 + 1) chk16("be00_fetch_addr", plog[n0].addr, 16'h9000);
    req(1, 0, 16'h9000, 2'b00, 16'h0, 16'h9000, 1, "be00_read_back");
    n0 = plog.size();
    req(1, 0, 16'h5670, 2'b00, 16'h0, 16'h5000, 0, "be00_clean_evict");
    chki("clean_evict_count", plog.size(), n0 + 1);
    if (plog.size() == n0 + 1) chki("clean_evict_no_wb", int'(plog[n0].wr), 0);

    // Reset while a fetch is outstanding
    do_reset();
    hold = 1;
    @(negedge clk);
    mem_address = 16'h5672; mem_read = 1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pmem_read) begin got = 1; break; end
    end
    chki("midfetch_pmem_read_seen", int'(got), 1);
    #2 rst_n = 1'b0;
    #1;
    chk16("midfetch_pmem_read_drop", 16'(pmem_read), 16'h0);
    chk16("midfetch_mem_resp", 16'(mem_resp), 16'h0);
    mem_read = 0;
    @(negedge clk);
    rst_n = 1'b1;
    hold = 0;
    n0 = plog.size();
    req(1, 0, 16'h5672, 2'b00, 16'h0, 16'h5001, 0, "refetch_after_reset");
    chki("refetch_count", plog.size(), n0 + 1);
    if (plog.size() == n0 + 1) chk16("refetch_addr", plog[n0].addr, 16'h5670);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
